// File: rtl/cpu24_pkg.sv
// rtl/cpu24_pkg.sv - shared widths, reset PC and fetch state encoding for the cpu24 core
package cpu24_pkg;

   localparam int INSTR_W = 32;
   localparam int JIDX_W  = 26;

   localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetchState_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - decode-side redirect inputs and fetch-side PC outputs of pc_fetch_unit
interface pc_fetch_unit_if;
   import cpu24_pkg::*;

   logic               stall;
   logic               halt;
   logic               branch_taken;
   logic [INSTR_W-1:0] imm_ext;
   logic               jump;
   logic [JIDX_W-1:0]  jump_index;
   logic               jr;
   logic [INSTR_W-1:0] jr_addr;
   logic [INSTR_W-1:0] pc;
   logic [INSTR_W-1:0] pc_id;
   logic [INSTR_W-1:0] pc_id_plus4;
   logic               id_valid;
   logic               flush;
   logic               halted;

   modport master (
      output stall, halt, branch_taken, imm_ext, jump, jump_index, jr, jr_addr,
      input  pc, pc_id, pc_id_plus4, id_valid, flush, halted
   );

   modport slave (
      input  stall, halt, branch_taken, imm_ext, jump, jump_index, jr, jr_addr,
      output pc, pc_id, pc_id_plus4, id_valid, flush, halted
   );

endinterface

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational redirect target and priority select (jr > jump > branch)
module pc_target_calc
   import cpu24_pkg::*;
(
   input  logic [INSTR_W-1:0] pcIdPlus4,
   input  logic [INSTR_W-1:0] immExt,
   input  logic [JIDX_W-1:0]  jumpIndex,
   input  logic [INSTR_W-1:0] jrAddr,
   input  logic               jr,
   input  logic               jump,
   input  logic               branchTaken,
   input  logic               idValid,
   output logic               redirect,
   output logic [INSTR_W-1:0] target
);

   logic [INSTR_W-1:0] jrTarget;
   logic [INSTR_W-1:0] jumpTarget;
   logic [INSTR_W-1:0] branchTarget;

   assign jrTarget     = jrAddr & ~32'h0000_0003;
   assign jumpTarget   = {pcIdPlus4[31:28], jumpIndex, 2'b00};
   // Wraps modulo 2^32 by construction; a backward branch near 0 is legal.
   assign branchTarget = pcIdPlus4 + (immExt << 2);

   // A bubble in decode carries garbage control bits, so nothing redirects without idValid.
   always_comb begin
      redirect = 1'b0;
      target   = pcIdPlus4;
      if (idValid) begin
         if (jr) begin
            redirect = 1'b1;
            target   = jrTarget;
         end else if (jump) begin
            redirect = 1'b1;
            target   = jumpTarget;
         end else if (branchTaken) begin
            redirect = 1'b1;
            target   = branchTarget;
         end
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC/fetch sequencer with redirect, stall, flush and halt; BRANCH_DELAY_SLOT_EN keeps the delay-slot fetch
module pc_fetch_unit
   import cpu24_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic            clk,
   input  logic            rst_n,
   pc_fetch_unit_if.slave  fetchBus
);

   fetchState_e        state;
   logic [INSTR_W-1:0] pcQ;
   logic [INSTR_W-1:0] pcIdQ;
   logic [INSTR_W-1:0] pcIdPlus4;
   logic               idValidQ;
   logic               haltedQ;
   logic               redirect;
   logic [INSTR_W-1:0] target;
   logic               advance;

   assign pcIdPlus4 = pcIdQ + 32'd4;
   assign advance   = (state == RUN) && !fetchBus.stall && !fetchBus.halt;

   pc_target_calc u_targetCalc (
      .pcIdPlus4   (pcIdPlus4),
      .immExt      (fetchBus.imm_ext),
      .jumpIndex   (fetchBus.jump_index),
      .jrAddr      (fetchBus.jr_addr),
      .jr          (fetchBus.jr),
      .jump        (fetchBus.jump),
      .branchTaken (fetchBus.branch_taken),
      .idValid     (idValidQ),
      .redirect    (redirect),
      .target      (target)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BOOT;
         pcQ      <= RESET_PC;
         pcIdQ    <= RESET_PC;
         idValidQ <= 1'b0;
         haltedQ  <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               pcQ      <= RESET_PC;
               idValidQ <= 1'b0;
               state    <= RUN;
            end
            RUN: begin
               if (!fetchBus.stall) begin
                  if (fetchBus.halt) begin
                     state    <= HALTED;
                     idValidQ <= 1'b0;
                     haltedQ  <= 1'b1;
                  end else begin
                     pcIdQ <= pcQ;
                     if (redirect) begin
                        pcQ <= target;
`ifdef BRANCH_DELAY_SLOT_EN
                        idValidQ <= 1'b1;
`else
                        idValidQ <= 1'b0;
`endif
                     end else begin
                        pcQ      <= pcQ + 32'd4;
                        idValidQ <= 1'b1;
                     end
                  end
               end
            end
            HALTED: begin
               idValidQ <= 1'b0;
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

`ifdef BRANCH_DELAY_SLOT_EN
   assign fetchBus.flush = 1'b0;
`else
   assign fetchBus.flush = advance && redirect;
`endif

   assign fetchBus.pc          = pcQ;
   assign fetchBus.pc_id       = pcIdQ;
   assign fetchBus.pc_id_plus4 = pcIdPlus4;
   assign fetchBus.id_valid    = idValidQ;
   assign fetchBus.halted      = haltedQ;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   pc_fetch_unit_if bus ();

   pc_fetch_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .fetchBus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clearInputs();
      bus.stall        = 1'b0;
      bus.halt         = 1'b0;
      bus.branch_taken = 1'b0;
      bus.imm_ext      = 32'h0;
      bus.jump         = 1'b0;
      bus.jump_index   = 26'h0;
      bus.jr           = 1'b0;
      bus.jr_addr      = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      clearInputs();
      rst_n = 1'b0;
      repeat (2) tick();
      check("rst_pc", bus.pc, 32'h0);
      check("rst_pc_id", bus.pc_id, 32'h0);
      check("rst_id_valid", bus.id_valid, 0);
      check("rst_halted", bus.halted, 0);
      check("rst_flush", bus.flush, 0);

      rst_n = 1'b1;
      tick();
      check("boot_pc", bus.pc, 32'h0);
      check("boot_id_valid", bus.id_valid, 0);
      tick();
      check("seq_pc4", bus.pc, 32'h4);
      check("seq_pc4_valid", bus.id_valid, 1);
      check("seq_pc4_pc_id", bus.pc_id, 32'h0);
      tick();
      check("seq_pc8", bus.pc, 32'h8);
      tick();
      check("seq_pc12", bus.pc, 32'hC);
      check("seq_pc12_pc_id", bus.pc_id, 32'h8);

      // jr to 0x100 to set up the branch case
      bus.jr = 1'b1; bus.jr_addr = 32'h0000_0103;
      #1;
      check("jr100_flush", bus.flush, DS ? 0 : 1);
      tick();
      clearInputs();
      check("jr100_pc", bus.pc, 32'h100);
      check("jr100_valid", bus.id_valid, DS ? 1 : 0);
      tick();
      check("pre_br_pc_id", bus.pc_id, 32'h100);
      check("pre_br_plus4", bus.pc_id_plus4, 32'h104);
      check("pre_br_valid", bus.id_valid, 1);

      bus.branch_taken = 1'b1; bus.imm_ext = 32'hFFFF_FFFE;
      #1;
      check("br_flush", bus.flush, DS ? 0 : 1);
      tick();
      check("br_pc", bus.pc, 32'h0FC);
      check("br_valid", bus.id_valid, DS ? 1 : 0);
      check("br_pc_id", bus.pc_id, 32'h104);
      // Branch still asserted: ignored as bubble garbage without DS, taken to 0x100 with DS
      #1;
      check("bubble_flush", bus.flush, 0);
      tick();
      clearInputs();
      check("bubble_pc", bus.pc, 32'h100);
      check("bubble_pc_id", bus.pc_id, 32'h0FC);
      check("bubble_valid", bus.id_valid, 1);

      // Jump from pc_id = 0x4000_0010
      bus.jr = 1'b1; bus.jr_addr = 32'h4000_0010;
      tick();
      clearInputs();
      tick();
      check("pre_j_pc_id", bus.pc_id, 32'h4000_0010);
      check("pre_j_valid", bus.id_valid, 1);
      bus.jump = 1'b1; bus.jump_index = 26'h0000040;
      tick();
      clearInputs();
      check("j_pc", bus.pc, 32'h4000_0100);
      tick();
      check("post_j_pc", bus.pc, 32'h4000_0104);

      // jr and jump together: jr wins, low bits cleared
      bus.jr = 1'b1; bus.jr_addr = 32'h0000_2003;
      bus.jump = 1'b1; bus.jump_index = 26'h0000123;
      tick();
      clearInputs();
      check("jr_pc", bus.pc, 32'h0000_2000);
      tick();
      check("post_jr_pc", bus.pc, 32'h0000_2004);
      check("post_jr_pc_id", bus.pc_id, 32'h0000_2000);

      // Stall with a pending taken branch
      bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.imm_ext = 32'h10;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_flush", bus.flush, 0);
         tick();
         check("stall_pc", bus.pc, 32'h2004);
         check("stall_pc_id", bus.pc_id, 32'h2000);
      end
      bus.stall = 1'b0;
      #1;
      check("unstall_flush", bus.flush, DS ? 0 : 1);
      tick();
      clearInputs();
      check("unstall_pc", bus.pc, 32'h2044);
      check("unstall_pc_id", bus.pc_id, 32'h2004);
      tick();
      check("once_pc", bus.pc, 32'h2048);

      // Wrap at the top of the address space
      bus.jr = 1'b1; bus.jr_addr = 32'hFFFF_FFFF;
      tick();
      clearInputs();
      check("top_pc", bus.pc, 32'hFFFF_FFFC);
      tick();
      check("wrap_pc", bus.pc, 32'h0);
      check("wrap_pc_id", bus.pc_id, 32'hFFFF_FFFC);
      check("wrap_plus4", bus.pc_id_plus4, 32'h0);
      tick();
      check("wrap_next_pc", bus.pc, 32'h4);

      // Halt beats a simultaneous jr
      bus.halt = 1'b1; bus.jr = 1'b1; bus.jr_addr = 32'h500;
      #1;
      check("halt_req_flush", bus.flush, 0);
      tick();
      check("halt_halted", bus.halted, 1);
      check("halt_pc", bus.pc, 32'h4);
      check("halt_valid", bus.id_valid, 0);
      for (int i = 0; i < 10; i++) begin
         bus.stall = i[0]; bus.halt = ~i[0]; bus.branch_taken = 1'b1;
         bus.jump = i[1]; bus.jr = i[2]; bus.imm_ext = 32'h3; bus.jr_addr = 32'h800;
         tick();
         check("halted_pc", bus.pc, 32'h4);
         check("halted_pc_id", bus.pc_id, 32'h0);
         check("halted_flag", bus.halted, 1);
         check("halted_flush", bus.flush, 0);
         check("halted_valid", bus.id_valid, 0);
      end

      clearInputs();
      rst_n = 1'b0;
      #1;
      check("rst2_pc", bus.pc, 32'h0);
      check("rst2_halted", bus.halted, 0);
      #2;
      rst_n = 1'b1;
      tick();
      check("boot2_pc", bus.pc, 32'h0);
      check("boot2_valid", bus.id_valid, 0);
      tick();
      check("run2_pc", bus.pc, 32'h4);
      check("run2_valid", bus.id_valid, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage of the 32-bit MIPS-style core.
- Sits directly downstream of the immediate extender: it consumes the 32-bit extended immediate as the branch offset.
- Produces the fetch address for instruction memory, and tracks the PC of the instruction currently in decode.
- Performs branch, jump and jump-register redirects, stall hold, flush generation and halt.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard stall; holds the PC and the decode-side registers.
- halt  in  1  decode holds a HALT instruction; enters HALTED.
- branch_taken  in  1  conditional branch in decode resolved taken.
- imm_ext  in  32  extended immediate from the extender (sign-extended for branches).
- jump  in  1  J/JAL in decode.
- jump_index  in  26  instr[25:0] of the jump.
- jr  in  1  JR/JALR in decode.
- jr_addr  in  32  register-file target.
- pc  out  32  current fetch address to instruction memory.
- pc_id  out  32  address of the instruction in decode.
- pc_id_plus4  out  32  pc_id + 4 (link value for JAL/JALR).
- id_valid  out  1  decode holds a valid instruction.
- flush  out  1  wrong-path fetch being squashed this cycle.
- halted  out  1  block is in HALTED.

Behaviour:
- Reset values (async, while rst_n=0):
  - pc = RESET_PC, pc_id = RESET_PC.
  - id_valid = 0, flush = 0, halted = 0.
  - state = BOOT.
- States:
  - BOOT: one cycle. pc stays RESET_PC; id_valid <= 0. Moves to RUN unconditionally.
  - RUN: normal fetch.
  - HALTED: absorbing; left only by rst_n.
- RUN, stall=1:
  - pc, pc_id and id_valid hold.
  - flush = 0.
  - Redirect and halt inputs are ignored; decode re-presents them after the stall.
- RUN, stall=0. Input priority: halt > jr > jump > branch_taken (only when id_valid=1) > sequential.
  - halt: next state HALTED; pc holds; id_valid <= 0; halted <= 1.
  - jr: target = {jr_addr[31:2], 2'b00}.
  - jump: target = {pc_id_plus4[31:28], jump_index, 2'b00}.
  - branch_taken: target = pc_id_plus4 + (imm_ext << 2), modulo 2^32 (wrap-around allowed, no trap).
  - sequential: pc <= pc + 4, wrapping at 32'hFFFF_FFFC -> 0.
  - Every advance: pc_id <= pc.
- Redirect:
  - pc <= target.
  - flush is combinational and asserted in the same cycle.
  - id_valid <= 0 (without the optional feature).
- Redirect inputs seen while id_valid=0 are ignored; they are bubble garbage.
- HALTED:
  - All registers frozen; id_valid = 0; flush = 0.
  - stall is ignored.
- Latency: one cycle from redirect request to target on pc.
- Throughput: one fetch per cycle when not stalled.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics):
  - The fetch at pc_id+4 is kept: flush is tied 0 and id_valid <= 1 on a redirect.
  - Target formulas are unchanged.
  - A redirect requested while decode holds a delay-slot instruction is still honoured (back-to-back branches follow the second target).
- Undefined: flush-on-redirect as described in Behaviour.

Decomposition:
- Shared package cpu24_pkg holds:
  - RESET_PC default.
  - Fetch state encoding (BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2).
  - INSTR_W = 32, JIDX_W = 26.
- One natural sub-module, pc_target_calc:
  - Purely combinational.
  - Computes the branch, jump and jr targets and the priority select.
  - Instantiated once inside pc_fetch_unit.

Test Plan:
- Reset then release:
  - During reset: pc=0, id_valid=0.
  - Release cycle 1 (BOOT): pc=0.
  - Then pc = 4, 8, 12, with id_valid=1 from the cycle pc=4.
- Branch: pc_id=0x100, branch_taken=1, imm_ext=0xFFFF_FFFE.
  - Next pc=0x0FC.
  - flush=1 in the request cycle, then id_valid=0 for one cycle.
  - With BRANCH_DELAY_SLOT_EN: flush=0 and id_valid stays 1.
- Jump and jr:
  - pc_id=0x4000_0010, jump_index=0x0000040 -> pc=0x4000_0100.
  - jr with jr_addr=0x0000_2003 -> pc=0x0000_2000.
  - jr and jump asserted together -> the jr target wins.
- Stall: stall=1 for 3 cycles with branch_taken=1.
  - pc and pc_id are frozen and flush=0.
  - On release the branch is taken exactly once.
- Wrap and halt:
  - pc=0xFFFF_FFFC sequential -> 0x0000_0000.
  - halt=1 -> halted=1, pc frozen for 10 cycles under any inputs.
  - rst_n pulse mid-HALTED returns to BOOT with pc=RESET_PC.
